// File: rtl/multi_slot_calibration.sv
// Window-averaging colour calibration into NUM_SLOTS YUV slots with registered readback.
// Optional macro CAL_RGB_BYPASS_EN adds rgb_yuv to store the raw RGB average instead of YUV.
module multi_slot_calibration #(
    parameter int unsigned WIN_LOG2  = 2,
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned SLOT_W    = 2,
    parameter int unsigned POS_W     = 13,
    parameter int unsigned CUR_W     = 10
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [SLOT_W-1:0]       wr_slot,
    input  logic                    pix_valid,
    input  logic [7:0]              raw_R,
    input  logic [7:0]              raw_G,
    input  logic [7:0]              raw_B,
    input  logic [POS_W-1:0]        row,
    input  logic [POS_W-1:0]        col,
    input  logic                    frame_end,
    input  logic [CUR_W-1:0]        cur_row,
    input  logic [CUR_W-1:0]        cur_col,
    input  logic [SLOT_W-1:0]       rd_slot,
`ifdef CAL_RGB_BYPASS_EN
    input  logic                    rgb_yuv,
`endif
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [NUM_SLOTS-1:0]    slot_valid,
    output logic [7:0]              Y_out,
    output logic signed [8:0]       U_out,
    output logic signed [8:0]       V_out
);

    localparam int unsigned ACC_W = 8 + 2 * WIN_LOG2;
    localparam int unsigned CNT_W = 2 * WIN_LOG2 + 1;
    localparam int unsigned WIN   = 1 << WIN_LOG2;
    localparam int unsigned NPIX  = 1 << (2 * WIN_LOG2);
    localparam int unsigned CMP_W = ((POS_W > CUR_W) ? POS_W : CUR_W) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_ACCUM, S_AVG, S_CONV, S_WRITE
    } state_e;

    state_e state_q, state_d;

    logic [SLOT_W-1:0]  slot_q;
    logic [CUR_W-1:0]   crow_q, ccol_q;
    logic [ACC_W-1:0]   acc_r_q, acc_g_q, acc_b_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [7:0]         avg_r_q, avg_g_q, avg_b_q;
    logic               fail_q;
    logic [7:0]         y_q;
    logic signed [8:0]  u_q, v_q;
    logic               busy_q, done_q, err_q;
    logic [NUM_SLOTS-1:0] valid_q;
    logic [7:0]         slot_y_q [NUM_SLOTS];
    logic signed [8:0]  slot_u_q [NUM_SLOTS];
    logic signed [8:0]  slot_v_q [NUM_SLOTS];
    logic [7:0]         rd_y_q;
    logic signed [8:0]  rd_u_q, rd_v_q;
    logic               use_rgb_c;

`ifdef CAL_RGB_BYPASS_EN
    logic rgb_q;
    assign use_rgb_c = rgb_q;
`else
    assign use_rgb_c = 1'b0;
`endif

    // Window hit test; widened so cursor + window cannot wrap
    logic [CMP_W-1:0] row_x, col_x, crow_x, ccol_x;
    logic             in_win_c;
    always_comb begin
        row_x    = CMP_W'(row);
        col_x    = CMP_W'(col);
        crow_x   = CMP_W'(crow_q);
        ccol_x   = CMP_W'(ccol_q);
        in_win_c = pix_valid
                 && (row_x >= crow_x) && (row_x < crow_x + CMP_W'(WIN))
                 && (col_x >= ccol_x) && (col_x < ccol_x + CMP_W'(WIN));
    end

    logic fail_c;
    assign fail_c = (cnt_q != CNT_W'(NPIX));

    function automatic logic signed [8:0] sat9(input logic signed [17:0] x);
        if (x > 18'sd255)       return 9'sd255;
        else if (x < -18'sd256) return 9'sh100;
        else                    return 9'(x);
    endfunction

    // RGB -> YUV with floor shifts and saturation
    logic signed [17:0] r_s, g_s, b_s, y_m, u_m, v_m, y_sh;
    logic [7:0]         y_c;
    logic signed [8:0]  u_c, v_c;
    always_comb begin
        r_s  = $signed({10'd0, avg_r_q});
        g_s  = $signed({10'd0, avg_g_q});
        b_s  = $signed({10'd0, avg_b_q});
        y_m  = 18'sd77 * r_s + 18'sd150 * g_s + 18'sd29 * b_s;
        u_m  = 18'sd128 * b_s - 18'sd43 * r_s - 18'sd85 * g_s;
        v_m  = 18'sd128 * r_s - 18'sd107 * g_s - 18'sd21 * b_s;
        y_sh = y_m >>> 8;
        if (y_sh > 18'sd255)    y_c = 8'd255;
        else if (y_sh < 18'sd0) y_c = 8'd0;
        else                    y_c = 8'(y_sh);
        u_c  = sat9(u_m >>> 8);
        v_c  = sat9(v_m >>> 8);
    end

    logic [7:0]        wr_y_c;
    logic signed [8:0] wr_u_c, wr_v_c;
    logic              wr_now_c;
    always_comb begin
        wr_y_c   = use_rgb_c ? avg_r_q : y_q;
        wr_u_c   = use_rgb_c ? $signed({1'b0, avg_g_q}) : u_q;
        wr_v_c   = use_rgb_c ? $signed({1'b0, avg_b_q}) : v_q;
        wr_now_c = (state_q == S_WRITE) && !fail_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)     state_d = S_ARM;
            S_ARM:   if (frame_end) state_d = S_ACCUM;
            S_ACCUM: if (frame_end) state_d = S_AVG;
            S_AVG:   state_d = use_rgb_c ? S_WRITE : S_CONV;
            S_CONV:  state_d = S_WRITE;
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q  <= '0;
            crow_q  <= '0;
            ccol_q  <= '0;
            acc_r_q <= '0;
            acc_g_q <= '0;
            acc_b_q <= '0;
            cnt_q   <= '0;
            avg_r_q <= '0;
            avg_g_q <= '0;
            avg_b_q <= '0;
            fail_q  <= 1'b0;
            y_q     <= '0;
            u_q     <= '0;
            v_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= '0;
            rd_y_q  <= '0;
            rd_u_q  <= '0;
            rd_v_q  <= '0;
`ifdef CAL_RGB_BYPASS_EN
            rgb_q   <= 1'b0;
`endif
            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                slot_y_q[i] <= '0;
                slot_u_q[i] <= '0;
                slot_v_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    slot_q <= wr_slot;
                    crow_q <= cur_row;
                    ccol_q <= cur_col;
`ifdef CAL_RGB_BYPASS_EN
                    rgb_q  <= rgb_yuv;
`endif
                end
                S_ARM: if (frame_end) begin
                    acc_r_q <= '0;
                    acc_g_q <= '0;
                    acc_b_q <= '0;
                    cnt_q   <= '0;
                end
                S_ACCUM: if (in_win_c) begin
                    acc_r_q <= acc_r_q + ACC_W'(raw_R);
                    acc_g_q <= acc_g_q + ACC_W'(raw_G);
                    acc_b_q <= acc_b_q + ACC_W'(raw_B);
                    cnt_q   <= cnt_q + CNT_W'(1);
                end
                S_AVG: begin
                    avg_r_q <= 8'(acc_r_q >> (2 * WIN_LOG2));
                    avg_g_q <= 8'(acc_g_q >> (2 * WIN_LOG2));
                    avg_b_q <= 8'(acc_b_q >> (2 * WIN_LOG2));
                    fail_q  <= fail_c;
                end
                S_CONV: begin
                    y_q <= y_c;
                    u_q <= u_c;
                    v_q <= v_c;
                end
                S_WRITE: begin
                    if (!fail_q) begin
                        slot_y_q[slot_q] <= wr_y_c;
                        slot_u_q[slot_q] <= wr_u_c;
                        slot_v_q[slot_q] <= wr_v_c;
                        valid_q[slot_q]  <= 1'b1;
                    end else begin
                        valid_q[slot_q]  <= 1'b0;
                    end
                end
                default: ;
            endcase

            busy_q <= (state_d != S_IDLE);
            done_q <= (state_d == S_WRITE);
            // In the bypass path WRITE follows AVG directly, so fail_q is not yet loaded
            err_q  <= (state_d == S_WRITE) && ((state_q == S_AVG) ? fail_c : fail_q);

            // Forward a same-cycle write so readback sees new data one cycle after WRITE
            if (wr_now_c && (rd_slot == slot_q)) begin
                rd_y_q <= wr_y_c;
                rd_u_q <= wr_u_c;
                rd_v_q <= wr_v_c;
            end else begin
                rd_y_q <= slot_y_q[rd_slot];
                rd_u_q <= slot_u_q[rd_slot];
                rd_v_q <= slot_v_q[rd_slot];
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign slot_valid = valid_q;
    assign Y_out      = rd_y_q;
    assign U_out      = rd_u_q;
    assign V_out      = rd_v_q;

endmodule

// File: tb/tb_multi_slot_calibration.sv
// Randomised bench for multi_slot_calibration against a frame-level average/YUV model.
module tb_multi_slot_calibration;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [1:0]        wr_slot;
    logic              pix_valid;
    logic [7:0]        raw_R, raw_G, raw_B;
    logic [12:0]       row, col;
    logic              frame_end;
    logic [9:0]        cur_row, cur_col;
    logic [1:0]        rd_slot;
    logic              busy, done, err;
    logic [3:0]        slot_valid;
    logic [7:0]        Y_out;
    logic signed [8:0] U_out, V_out;
`ifdef CAL_RGB_BYPASS_EN
    logic              rgb_yuv;
`endif

    multi_slot_calibration dut (
        .clk(clk), .reset_n(reset_n), .start(start), .wr_slot(wr_slot),
        .pix_valid(pix_valid), .raw_R(raw_R), .raw_G(raw_G), .raw_B(raw_B),
        .row(row), .col(col), .frame_end(frame_end),
        .cur_row(cur_row), .cur_col(cur_col), .rd_slot(rd_slot),
`ifdef CAL_RGB_BYPASS_EN
        .rgb_yuv(rgb_yuv),
`endif
        .busy(busy), .done(done), .err(err), .slot_valid(slot_valid),
        .Y_out(Y_out), .U_out(U_out), .V_out(V_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: slot contents and window sums of the frame being accumulated
    int m_y [4];
    int m_u [4];
    int m_v [4];
    bit m_valid [4];
    int sr, sg, sb, scnt;
    int mrow, mcol;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int fdiv256(input int x);
        return (x >= 0) ? x / 256 : -((-x + 255) / 256);
    endfunction

    function automatic int clamp(input int x, input int lo, input int hi);
        return (x < lo) ? lo : ((x > hi) ? hi : x);
    endfunction

    function automatic int valid_mask();
        int m = 0;
        for (int i = 0; i < 4; i++) if (m_valid[i]) m |= (1 << i);
        return m;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            m_y[i] = 0; m_u[i] = 0; m_v[i] = 0; m_valid[i] = 0;
        end
    endtask

    // Emit an h x w pixel block with random invalid gaps, then a frame_end pulse
    task automatic send_frame(input int r0, input int c0, input int h, input int w,
                              input bit acc, input bit fixed, input int fr, input int fg, input int fb);
        for (int r = r0; r < r0 + h; r++) begin
            for (int c = c0; c < c0 + w; c++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(negedge clk);
                    pix_valid = 1'b0; frame_end = 1'b0;
                    row = 13'(mrow + int'($urandom_range(0, 3)));
                    col = 13'(mcol + int'($urandom_range(0, 3)));
                    raw_R = 8'($urandom); raw_G = 8'($urandom); raw_B = 8'($urandom);
                end
                @(negedge clk);
                pix_valid = 1'b1; frame_end = 1'b0;
                row = 13'(r); col = 13'(c);
                if (fixed) begin
                    raw_R = 8'(fr); raw_G = 8'(fg); raw_B = 8'(fb);
                end else begin
                    raw_R = 8'($urandom); raw_G = 8'($urandom); raw_B = 8'($urandom);
                end
                if (acc && r >= mrow && r < mrow + 4 && c >= mcol && c < mcol + 4) begin
                    sr += int'(raw_R); sg += int'(raw_G); sb += int'(raw_B); scnt++;
                end
            end
        end
        @(negedge clk);
        pix_valid = 1'b0; frame_end = 1'b1;
    endtask

    task automatic read_all(input string tag);
        for (int s = 0; s < 4; s++) begin
            @(negedge clk); rd_slot = 2'(s);
            @(negedge clk);
            chk($sformatf("%s_Y%0d", tag, s), int'(Y_out), m_y[s]);
            chk($sformatf("%s_U%0d", tag, s), int'(U_out), m_u[s]);
            chk($sformatf("%s_V%0d", tag, s), int'(V_out), m_v[s]);
        end
    endtask

    task automatic run_op(input string tag, input int slot, input int crow, input int ccol,
                          input int r0, input int c0, input int h, input int w,
                          input bit fixed, input int fr, input int fg, input int fb,
                          input bit coinc, input bit hold, input bit byp);
        int ndone, first, errv, ar, ag, ab, exp_err;
        mrow = crow; mcol = ccol;
        sr = 0; sg = 0; sb = 0; scnt = 0;
        @(negedge clk);
        start = 1'b1; wr_slot = 2'(slot);
        cur_row = 10'(crow); cur_col = 10'(ccol);
        frame_end = coinc; pix_valid = 1'b0;
`ifdef CAL_RGB_BYPASS_EN
        rgb_yuv = byp;
`endif
        @(negedge clk);
        start = hold; frame_end = 1'b0;
        wr_slot = 2'($urandom); cur_row = 10'($urandom); cur_col = 10'($urandom);
`ifdef CAL_RGB_BYPASS_EN
        rgb_yuv = 1'($urandom);
`endif
        chk({tag, "_busy"}, int'(busy), 1);
        send_frame(r0, c0, h, w, 1'b0, 1'b0, 0, 0, 0);
        send_frame(r0, c0, h, w, 1'b1, fixed, fr, fg, fb);
        ndone = 0; first = 0; errv = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            frame_end = 1'b0; start = 1'b0;
            if (done) begin
                ndone++;
                if (first == 0) begin first = i; errv = int'(err); end
            end
        end
        exp_err = (scnt != 16) ? 1 : 0;
        chk({tag, "_ndone"}, ndone, 1);
        chk({tag, "_latency"}, first, byp ? 2 : 3);
        chk({tag, "_err"}, errv, exp_err);
        chk({tag, "_busy_end"}, int'(busy), 0);
        if (exp_err == 0) begin
            ar = sr / 16; ag = sg / 16; ab = sb / 16;
            if (byp) begin
                m_y[slot] = ar; m_u[slot] = ag; m_v[slot] = ab;
            end else begin
                m_y[slot] = clamp((77 * ar + 150 * ag + 29 * ab) / 256, 0, 255);
                m_u[slot] = clamp(fdiv256(128 * ab - 43 * ar - 85 * ag), -256, 255);
                m_v[slot] = clamp(fdiv256(128 * ar - 107 * ag - 21 * ab), -256, 255);
            end
            m_valid[slot] = 1'b1;
        end else begin
            m_valid[slot] = 1'b0;
        end
        chk({tag, "_slot_valid"}, int'(slot_valid), valid_mask());
        read_all(tag);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_valid"}, int'(slot_valid), 0);
        chk({tag, "_Y"}, int'(Y_out), 0);
        chk({tag, "_U"}, int'(U_out), 0);
        chk({tag, "_V"}, int'(V_out), 0);
    endtask

    initial begin
        int nd, slot, r0, c0, crow, ccol;
        bit byp;
        reset_n = 1'b0; start = 1'b0; wr_slot = '0; pix_valid = 1'b0;
        raw_R = '0; raw_G = '0; raw_B = '0; row = '0; col = '0; frame_end = 1'b0;
        cur_row = '0; cur_col = '0; rd_slot = '0;
`ifdef CAL_RGB_BYPASS_EN
        rgb_yuv = 1'b0;
`endif
        clear_model();
        repeat (3) @(negedge clk);
        chk_zero("rst");
        reset_n = 1'b1;
        @(negedge clk);
        chk_zero("rst_rel");

        run_op("gray", 0, 12, 22, 10, 20, 8, 8, 1'b1, 100, 100, 100, 1'b0, 1'b0, 1'b0);
        run_op("red", 2, 101, 203, 100, 200, 8, 8, 1'b1, 255, 0, 0, 1'b0, 1'b0, 1'b0);
        run_op("clip", 0, 477, 637, 470, 630, 10, 10, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        run_op("hold", 1, 33, 44, 30, 40, 8, 8, 1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b0);

        // Abort during accumulation: no done, everything back to zero
        mrow = 52; mcol = 62;
        @(negedge clk);
        start = 1'b1; wr_slot = 2'd3; cur_row = 10'd52; cur_col = 10'd62;
        @(negedge clk);
        start = 1'b0;
        send_frame(50, 60, 8, 8, 1'b0, 1'b0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            frame_end = 1'b0; pix_valid = 1'b1; row = 13'd52; col = 13'(62 + k);
        end
        reset_n = 1'b0; pix_valid = 1'b0;
        clear_model();
        @(negedge clk);
        chk_zero("abort");
        reset_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("abort_nodone", nd, 0);
        chk_zero("abort_idle");
        run_op("fresh", 3, 12, 12, 10, 10, 8, 8, 1'b1, 10, 200, 90, 1'b0, 1'b0, 1'b0);

`ifdef CAL_RGB_BYPASS_EN
        run_op("byp", 1, 12, 12, 10, 10, 8, 8, 1'b1, 50, 150, 250, 1'b0, 1'b0, 1'b1);
`endif

        for (int it = 0; it < 12; it++) begin
            slot = int'($urandom_range(0, 3));
            r0 = int'($urandom_range(0, 900));
            c0 = int'($urandom_range(0, 900));
            if ($urandom_range(0, 3) == 0) begin
                crow = r0 + 8 - int'($urandom_range(1, 3));
                ccol = c0 + int'($urandom_range(0, 4));
            end else begin
                crow = r0 + int'($urandom_range(0, 4));
                ccol = c0 + int'($urandom_range(0, 4));
            end
            byp = 1'b0;
`ifdef CAL_RGB_BYPASS_EN
            byp = 1'($urandom);
`endif
            run_op($sformatf("rnd%0d", it), slot, crow, ccol, r0, c0, 8, 8,
                   1'b0, 0, 0, 0, 1'($urandom), 1'b0, byp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
